// File: rtl/pc_history_unit_if.sv
// rtl/pc_history_unit_if.sv - control and observation bundle for the PC history unit
interface pc_history_unit_if #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4,
    parameter int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CNTW  = $clog2(DEPTH + 1)
);
    logic                   enable;
    logic [1:0]             next_sel;
    logic [WIDTH-1:0]       target;
    logic [IDXW-1:0]        rewind_idx;
    logic [WIDTH-1:0]       out;
    logic [WIDTH-1:0]       prev_out;
    logic [WIDTH*DEPTH-1:0] hist_flat;
    logic [CNTW-1:0]        hist_count;
    logic                   wrap;
    logic                   rewind_err;

    modport master (
        output enable, next_sel, target, rewind_idx,
        input  out, prev_out, hist_flat, hist_count, wrap, rewind_err
    );

    modport slave (
        input  enable, next_sel, target, rewind_idx,
        output out, prev_out, hist_flat, hist_count, wrap, rewind_err
    );
endinterface

// File: rtl/pc_history_unit.sv
// rtl/pc_history_unit.sv - program counter with selectable next-PC source and rewindable history
module pc_history_unit #(
    parameter int               WIDTH     = 12,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int               IDXW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int               CNTW      = $clog2(DEPTH + 1)
) (
    input logic              clk,
    input logic              clr,
    pc_history_unit_if.slave bus
);
    logic [WIDTH-1:0] pc, pc_n;
    logic [WIDTH-1:0] hist [DEPTH];
    logic [WIDTH-1:0] hist_n [DEPTH];
    logic [CNTW-1:0]  cnt, cnt_n;
    logic             wrap_q, wrap_n;
    logic             err_q, err_n;
    logic [WIDTH:0]   sum_inc;
    logic [WIDTH+1:0] sum_br;
    logic             rewind_ok;

    // Two guard bits let the branch sum represent both underflow and overflow.
    assign sum_inc   = {1'b0, pc} + {{WIDTH{1'b0}}, 1'b1};
    assign sum_br    = {2'b00, pc} + {{(WIDTH+1){1'b0}}, 1'b1}
                     + {{2{bus.target[WIDTH-1]}}, bus.target};
    assign rewind_ok = int'(bus.rewind_idx) < int'(cnt);

    always_comb begin
        pc_n   = pc;
        hist_n = hist;
        cnt_n  = cnt;
        wrap_n = 1'b0;
        err_n  = 1'b0;
        if (bus.enable) begin
            if (bus.next_sel != 2'b11) begin
                case (bus.next_sel)
                    2'b00: begin
                        pc_n   = sum_inc[WIDTH-1:0];
                        wrap_n = sum_inc[WIDTH];
                    end
                    2'b01: begin
                        pc_n   = sum_br[WIDTH-1:0];
                        wrap_n = sum_br[WIDTH+1] | sum_br[WIDTH];
                    end
                    default: pc_n = bus.target;
                endcase
                hist_n[0] = pc;
                for (int k = 1; k < DEPTH; k++) hist_n[k] = hist[k-1];
                cnt_n = (cnt == CNTW'(DEPTH)) ? cnt : cnt + 1'b1;
            end else if (rewind_ok) begin
                for (int j = 0; j < DEPTH; j++)
                    if (j == int'(bus.rewind_idx)) pc_n = hist[j];
                // Drop the restored entry and everything newer than it.
                for (int k = 0; k < DEPTH; k++) begin
                    hist_n[k] = '0;
                    for (int j = 0; j < DEPTH; j++)
                        if (j == k + int'(bus.rewind_idx) + 1) hist_n[k] = hist[j];
                end
                cnt_n = CNTW'(int'(cnt) - int'(bus.rewind_idx) - 1);
            end else begin
                err_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            pc     <= RESET_VEC;
            cnt    <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
            for (int k = 0; k < DEPTH; k++) hist[k] <= '0;
        end else begin
            pc     <= pc_n;
            cnt    <= cnt_n;
            wrap_q <= wrap_n;
            err_q  <= err_n;
            for (int k = 0; k < DEPTH; k++) hist[k] <= hist_n[k];
        end
    end

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_flat
            assign bus.hist_flat[g*WIDTH +: WIDTH] = hist[g];
        end
    endgenerate

    assign bus.out        = pc;
    assign bus.prev_out   = hist[0];
    assign bus.hist_count = cnt;
    assign bus.wrap       = wrap_q;
    assign bus.rewind_err = err_q;
endmodule

// File: tb/tb_pc_history_unit.sv
// tb/tb_pc_history_unit.sv - scoreboard bench for pc_history_unit against a queue-based model
module tb_pc_history_unit;
    localparam int W = 12;
    localparam int D = 4;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    pc_history_unit_if #(.WIDTH(W), .DEPTH(D)) bus ();

    pc_history_unit #(.WIDTH(W), .DEPTH(D), .RESET_VEC(12'h000)) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    typedef struct {
        int           pc;
        int           cnt;
        logic [W*D-1:0] flat;
        bit           w;
        bit           e;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   done   = 0;

    int m_pc;
    int m_cnt;
    int mh[$];
    bit m_w, m_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input bit c, input bit en, input int sel, input int tgt, input int idx);
        int s;
        m_w = 0;
        m_e = 0;
        if (c) begin
            m_pc  = 0;
            m_cnt = 0;
            mh    = {0, 0, 0, 0};
        end else if (en) begin
            if (sel == 3) begin
                if (idx < m_cnt) begin
                    m_pc = mh[idx];
                    repeat (idx + 1) begin
                        void'(mh.pop_front());
                        mh.push_back(0);
                    end
                    m_cnt -= idx + 1;
                end else begin
                    m_e = 1;
                end
            end else begin
                mh.push_front(m_pc);
                void'(mh.pop_back());
                m_cnt = (m_cnt < D) ? m_cnt + 1 : D;
                if (sel == 0) begin
                    m_w  = (m_pc == 4095);
                    m_pc = (m_pc + 1) % 4096;
                end else if (sel == 1) begin
                    s    = m_pc + 1 + ((tgt >= 2048) ? tgt - 4096 : tgt);
                    m_w  = (s < 0) || (s > 4095);
                    m_pc = ((s % 4096) + 4096) % 4096;
                end else begin
                    m_pc = tgt;
                end
            end
        end
    endtask

    task automatic op(input bit c, input bit en, input int sel, input int tgt, input int idx);
        exp_t x;
        clr            = c;
        bus.enable     = en;
        bus.next_sel   = 2'(sel);
        bus.target     = 12'(tgt);
        bus.rewind_idx = 2'(idx);
        model(c, en, sel, tgt, idx);
        x.pc  = m_pc;
        x.cnt = m_cnt;
        for (int k = 0; k < D; k++) x.flat[k*W +: W] = 12'(mh[k]);
        x.w = m_w;
        x.e = m_e;
        @(posedge clk);
        q.push_back(x);
        #1;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("out",        64'(bus.out),        64'(x.pc));
                chk("prev_out",   64'(bus.prev_out),   64'(x.flat[W-1:0]));
                chk("hist_flat",  64'(bus.hist_flat),  64'(x.flat));
                chk("hist_count", 64'(bus.hist_count), 64'(x.cnt));
                chk("wrap",       64'(bus.wrap),       64'(x.w));
                chk("rewind_err", 64'(bus.rewind_err), 64'(x.e));
            end
        end
    end

    initial begin : stim
        int v;
        op(1, 0, 0, 0, 0);
        chk("rst_out", 64'(bus.out), 64'd0);
        chk("rst_cnt", 64'(bus.hist_count), 64'd0);
        chk("rst_flat", 64'(bus.hist_flat), 64'd0);

        repeat (5) op(0, 1, 0, 0, 0);
        chk("inc5_out", 64'(bus.out), 64'd5);
        chk("inc5_prev", 64'(bus.prev_out), 64'd4);
        chk("inc5_cnt", 64'(bus.hist_count), 64'd4);
        chk("inc5_flat", 64'(bus.hist_flat), 64'({12'd1, 12'd2, 12'd3, 12'd4}));

        op(0, 1, 2, 12'h010, 0);
        op(0, 1, 1, 12'hFFE, 0);
        chk("br_out", 64'(bus.out), 64'h00F);
        chk("br_prev", 64'(bus.prev_out), 64'h010);
        op(0, 1, 2, 12'h3A0, 0);
        chk("jmp_out", 64'(bus.out), 64'h3A0);
        chk("jmp_prev", 64'(bus.prev_out), 64'h00F);

        op(0, 1, 2, 12'hFFF, 0);
        op(0, 1, 0, 0, 0);
        chk("wrap_out", 64'(bus.out), 64'h000);
        chk("wrap_set", 64'(bus.wrap), 64'd1);
        op(0, 1, 0, 0, 0);
        chk("wrap_clr", 64'(bus.wrap), 64'd0);

        op(0, 1, 2, 12'h7FF, 0);
        op(0, 1, 1, 12'h001, 0);
        chk("br_nowrap", 64'(bus.wrap), 64'd0);
        op(0, 1, 2, 12'hFFF, 0);
        op(0, 1, 1, 12'h001, 0);
        chk("br_wrap", 64'(bus.wrap), 64'd1);

        op(1, 0, 0, 0, 0);
        repeat (4) op(0, 1, 0, 0, 0);
        op(0, 1, 3, 0, 2);
        chk("rw_out", 64'(bus.out), 64'd1);
        chk("rw_prev", 64'(bus.prev_out), 64'd0);
        chk("rw_cnt", 64'(bus.hist_count), 64'd1);
        chk("rw_err0", 64'(bus.rewind_err), 64'd0);
        op(0, 1, 3, 0, 1);
        chk("rw_err", 64'(bus.rewind_err), 64'd1);
        chk("rw_hold", 64'(bus.out), 64'd1);

        repeat (3) op(0, 0, $urandom_range(0, 3), $urandom_range(0, 4095), $urandom_range(0, 3));
        chk("stall_out", 64'(bus.out), 64'd1);
        chk("stall_cnt", 64'(bus.hist_count), 64'd1);

        op(0, 1, 2, 12'h123, 0);
        op(1, 1, 2, 12'h456, 0);
        chk("clr_out", 64'(bus.out), 64'd0);
        chk("clr_cnt", 64'(bus.hist_count), 64'd0);
        chk("clr_flat", 64'(bus.hist_flat), 64'd0);

        for (int i = 0; i < 400; i++) begin
            v = $urandom_range(0, 99);
            op(v == 0, v < 80, $urandom_range(0, 3), $urandom_range(0, 4095), $urandom_range(0, 3));
        end

        op(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
